// File: rtl/tia_timing_pkg.sv
// Shared horizontal/vertical timing definitions for the TIA counters:
// LFSR helpers, line geometry and decode indices.
package tia_timing_pkg;

  localparam int unsigned LFSR_W      = 6;
  localparam int unsigned LINE_STATES = 57;
  localparam int unsigned PHASES      = 4;
  localparam int unsigned PHASE_W     = 2;

  localparam int unsigned SHB  = 0;
  localparam int unsigned SHS  = 4;
  localparam int unsigned RHS  = 8;
  localparam int unsigned SCB  = 8;
  localparam int unsigned RCB  = 12;
  localparam int unsigned RHB  = 16;
  localparam int unsigned LRHB = 18;

  typedef logic [LFSR_W-1:0] lfsr_t;

  typedef struct packed {
    logic hblank_s_n;
    logic hblank_r_n;
    logic hsync_s_n;
    logic hsync_r_n;
    logic cburst_s_n;
    logic cburst_r_n;
  } hstrobe_t;

  // x^6+x^5+1 in XNOR form; all-ones is the lockup state
  function automatic lfsr_t lfsr_next(input lfsr_t q);
    return {q[LFSR_W-2:0], ~(q[LFSR_W-1] ^ q[LFSR_W-2])};
  endfunction

  // LFSR state reached after idx steps from zero
  function automatic lfsr_t lfsr_pattern(input int unsigned idx);
    lfsr_t s;
    s = '0;
    for (int unsigned i = 0; i < idx; i++) begin
      s = lfsr_next(s);
    end
    return s;
  endfunction

endpackage

// File: rtl/tia_lfsr6.sv
// 6-bit XNOR polynomial counter with step enable and synchronous load-zero.
// Shared by the horizontal, vertical and object counters.
module tia_lfsr6
  import tia_timing_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  step_i,
  input  logic  load_zero_i,
  output lfsr_t q_o
);

  lfsr_t lfsr_q;
  lfsr_t lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_zero_i) begin
      lfsr_d = '0;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/tia_hsync_counter.sv
// Horizontal timing generator: 57-state LFSR stepped every 4 colour clocks,
// decoded into one-clock active-low set/reset strobes for the line F1s.
module tia_hsync_counter
  import tia_timing_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              rsync_n,
  input  logic              hmove_strobe,
  output logic              hblank_s_n,
  output logic              hblank_r_n,
  output logic              hsync_s_n,
  output logic              hsync_r_n,
  output logic              cburst_s_n,
  output logic              cburst_r_n,
  output logic              hmove_active,
  output logic              line_start,
  output logic [LFSR_W-1:0] count
);

  localparam lfsr_t PAT_LAST = lfsr_pattern(LINE_STATES - 1);
  localparam lfsr_t PAT_SHB  = lfsr_pattern(SHB);
  localparam lfsr_t PAT_SHS  = lfsr_pattern(SHS);
  localparam lfsr_t PAT_RHS  = lfsr_pattern(RHS);
  localparam lfsr_t PAT_SCB  = lfsr_pattern(SCB);
  localparam lfsr_t PAT_RCB  = lfsr_pattern(RCB);
  localparam lfsr_t PAT_RHB  = lfsr_pattern(RHB);
  localparam lfsr_t PAT_LRHB = lfsr_pattern(LRHB);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               latch_q, latch_d;
  logic               late_q, late_d;
  hstrobe_t           strb_q, strb_d;
  logic               line_start_q, line_start_d;
  lfsr_t              lfsr_q;
  logic               step;
  logic               load_zero;
  logic               dec;

  assign step      = (phase_q == PHASE_W'(PHASES - 1));
  assign load_zero = !rsync_n || (step && (lfsr_q == PAT_LAST));
  assign dec       = (phase_q == '0);

  tia_lfsr6 u_lfsr (
    .clk        (clock),
    .rst_n      (reset),
    .step_i     (step),
    .load_zero_i(load_zero),
    .q_o        (lfsr_q)
  );

  // Next state: phase, HMOVE latch, and the latch value sampled at RHB time
  always_comb begin
    phase_d = phase_q + PHASE_W'(1);
    latch_d = latch_q;
    late_d  = late_q;
    if (!rsync_n) begin
      phase_d = '0;
    end
    if (load_zero) begin
      latch_d = 1'b0;
    end
    if (hmove_strobe) begin
      latch_d = 1'b1;
    end
    if (dec && (lfsr_q == PAT_RHB)) begin
      late_d = latch_q;
    end
  end

  // Strobe decode from the pre-edge state; registered below
  always_comb begin
    strb_d            = '1;
    strb_d.hblank_s_n = !(dec && (lfsr_q == PAT_SHB));
    strb_d.hsync_s_n  = !(dec && (lfsr_q == PAT_SHS));
    strb_d.hsync_r_n  = !(dec && (lfsr_q == PAT_RHS));
    strb_d.cburst_s_n = !(dec && (lfsr_q == PAT_SCB));
    strb_d.cburst_r_n = !(dec && (lfsr_q == PAT_RCB));
    strb_d.hblank_r_n = !(dec && (((lfsr_q == PAT_RHB) && !latch_q) ||
                                  ((lfsr_q == PAT_LRHB) && late_q)));
    line_start_d      = dec && (lfsr_q == PAT_SHB);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q      <= '0;
      latch_q      <= 1'b0;
      late_q       <= 1'b0;
      strb_q       <= '1;
      line_start_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      latch_q      <= latch_d;
      late_q       <= late_d;
      strb_q       <= strb_d;
      line_start_q <= line_start_d;
    end
  end

  assign hblank_s_n   = strb_q.hblank_s_n;
  assign hblank_r_n   = strb_q.hblank_r_n;
  assign hsync_s_n    = strb_q.hsync_s_n;
  assign hsync_r_n    = strb_q.hsync_r_n;
  assign cburst_s_n   = strb_q.cburst_s_n;
  assign cburst_r_n   = strb_q.cburst_r_n;
  assign line_start   = line_start_q;
  assign hmove_active = latch_q;
  assign count        = lfsr_q;

endmodule

// File: tb/tb_tia_hsync_counter.sv
// Directed bench for tia_hsync_counter; edges are counted from the first
// posedge after reset release (edge 1).
module tb_tia_hsync_counter;
  import tia_timing_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rsync_n = 1'b1;
  logic       hmove_strobe = 1'b0;
  logic       hblank_s_n, hblank_r_n, hsync_s_n, hsync_r_n;
  logic       cburst_s_n, cburst_r_n, hmove_active, line_start;
  logic [5:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  wire [6:0] obs = {line_start, hblank_s_n, hblank_r_n, hsync_s_n,
                    hsync_r_n, cburst_s_n, cburst_r_n};

  always #5 clock = ~clock;

  tia_hsync_counter dut (
    .clock       (clock),
    .reset       (reset),
    .rsync_n     (rsync_n),
    .hmove_strobe(hmove_strobe),
    .hblank_s_n  (hblank_s_n),
    .hblank_r_n  (hblank_r_n),
    .hsync_s_n   (hsync_s_n),
    .hsync_r_n   (hsync_r_n),
    .cburst_s_n  (cburst_s_n),
    .cburst_r_n  (cburst_r_n),
    .hmove_active(hmove_active),
    .line_start  (line_start),
    .count       (count)
  );

  function automatic logic [6:0] mkvec(input bit hbs, input bit hbr, input bit hss,
                                       input bit hsr, input bit cbs, input bit cbr);
    return {hbs, ~hbs, ~hbr, ~hss, ~hsr, ~cbs, ~cbr};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    edge_n++;
  endtask

  task automatic apply_reset();
    reset        = 1'b0;
    rsync_n      = 1'b1;
    hmove_strobe = 1'b0;
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++;
    if (obs !== mkvec(0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected %b", obs, mkvec(0, 0, 0, 0, 0, 0));
    end
    n_checks++;
    if (count !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_count: got %b expected 000000", count);
    end
    n_checks++;
    if (hmove_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hmove: got %b expected 0", hmove_active);
    end
  endtask

  task automatic test_free_run();
    logic [6:0] exp;
    apply_reset();
    for (int e = 1; e <= 232; e++) begin
      tick();
      exp = mkvec(e == 1 || e == 229, e == 65, e == 17, e == 33, e == 33, e == 49);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL free_run edge %0d: got %b expected %b", e, obs, exp);
      end
      if (e == 228) begin
        n_checks++;
        if (count !== 6'b000000) begin
          n_fail++;
          $display("FAIL free_run_wrap_count: got %b expected 000000", count);
        end
      end
    end
  endtask

  task automatic test_lfsr_coverage();
    logic [63:0] seen;
    lfsr_t       exp;
    seen = '0;
    apply_reset();
    for (int e = 1; e <= 228; e++) begin
      tick();
      exp = lfsr_pattern(((e / 4) % 57));
      seen[count] = 1'b1;
      n_checks++;
      if (count !== exp) begin
        n_fail++;
        $display("FAIL lfsr_count edge %0d: got %b expected %b", e, count, exp);
      end
      if (e == 4 || e == 20 || e == 24) begin
        exp = (e == 4) ? 6'b000001 : (e == 20) ? 6'b011111 : 6'b111110;
        n_checks++;
        if (count !== exp) begin
          n_fail++;
          $display("FAIL lfsr_hand edge %0d: got %b expected %b", e, count, exp);
        end
      end
    end
    n_checks++;
    if ($countones(seen) != 57) begin
      n_fail++;
      $display("FAIL lfsr_distinct: got %0d expected 57", $countones(seen));
    end
    n_checks++;
    if (seen[63] !== 1'b0) begin
      n_fail++;
      $display("FAIL lfsr_lockup: got %b expected 0", seen[63]);
    end
  endtask

  task automatic test_hmove(input int set_edge, input string name);
    logic exp_hbr, exp_act;
    apply_reset();
    for (int e = 1; e <= 300; e++) begin
      hmove_strobe = (e == set_edge);
      tick();
      exp_act = (e >= set_edge) && (e < 228);
      exp_hbr = (set_edge < 65) ? !(e == 73 || e == 293) : !(e == 65 || e == 293);
      n_checks++;
      if (hmove_active !== exp_act) begin
        n_fail++;
        $display("FAIL %s_active edge %0d: got %b expected %b", name, e, hmove_active, exp_act);
      end
      n_checks++;
      if (hblank_r_n !== exp_hbr) begin
        n_fail++;
        $display("FAIL %s_hbr edge %0d: got %b expected %b", name, e, hblank_r_n, exp_hbr);
      end
    end
    hmove_strobe = 1'b0;
  endtask

  task automatic test_rsync();
    logic [6:0] exp;
    apply_reset();
    for (int e = 1; e <= 170; e++) begin
      rsync_n      = !(e == 100);
      hmove_strobe = (e == 90);
      tick();
      exp = mkvec(e == 1 || e == 101, e == 65 || e == 165, e == 17 || e == 117,
                  e == 33 || e == 133, e == 33 || e == 133, e == 49 || e == 149);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rsync edge %0d: got %b expected %b", e, obs, exp);
      end
      n_checks++;
      if (hmove_active !== ((e >= 90) && (e < 100))) begin
        n_fail++;
        $display("FAIL rsync_hmove edge %0d: got %b expected %b", e, hmove_active,
                 ((e >= 90) && (e < 100)));
      end
      if (e == 100) begin
        n_checks++;
        if (count !== 6'b000000) begin
          n_fail++;
          $display("FAIL rsync_count: got %b expected 000000", count);
        end
      end
    end
    rsync_n      = 1'b1;
    hmove_strobe = 1'b0;
  endtask

  task automatic test_rsync_at_wrap();
    logic [6:0] exp;
    apply_reset();
    for (int e = 1; e <= 235; e++) begin
      rsync_n = !(e == 228);
      tick();
      exp = mkvec(e == 1 || e == 229, e == 65, e == 17, e == 33, e == 33, e == 49);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rsync_wrap edge %0d: got %b expected %b", e, obs, exp);
      end
      if (e == 228 || e == 232) begin
        n_checks++;
        if (count !== ((e == 228) ? 6'b000000 : 6'b000001)) begin
          n_fail++;
          $display("FAIL rsync_wrap_count edge %0d: got %b", e, count);
        end
      end
    end
    rsync_n = 1'b1;
  endtask

  task automatic test_reset_midline();
    logic [6:0] exp;
    apply_reset();
    for (int e = 1; e <= 17; e++) begin
      hmove_strobe = (e == 5);
      tick();
    end
    n_checks++;
    if (hsync_s_n !== 1'b0) begin
      n_fail++;
      $display("FAIL midline_pre_hss: got %b expected 0", hsync_s_n);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== mkvec(0, 0, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL midline_async_strobes: got %b expected %b", obs, mkvec(0, 0, 0, 0, 0, 0));
    end
    n_checks++;
    if (count !== 6'b000000 || hmove_active !== 1'b0) begin
      n_fail++;
      $display("FAIL midline_async_state: got count %b hmove %b expected 000000 0",
               count, hmove_active);
    end
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    edge_n = 0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp = mkvec(e == 1, 0, e == 17, 0, 0, 0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL midline_restart edge %0d: got %b expected %b", e, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_lfsr_coverage();
    test_hmove(40, "hmove");
    test_hmove(70, "late_hmove");
    test_rsync();
    test_rsync_at_wrap();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
